// File: rtl/sd_cmd_response_rx.sv
// SD CMD-line response receiver: deserializes R1/R1b/R2/R3/R6 MSB first, checks framing/CRC7/index
// and emits register-bank load strobes. Define SD_RESP_BUSY_WAIT_EN for the R1b DAT0 busy wait.
module sd_cmd_response_rx #(
    parameter int unsigned NCR_MAX = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_in,
    input  logic         start,
    input  logic [2:0]   resp_type,
    input  logic [5:0]   exp_index,
    input  logic         r2_is_csd,
    input  logic         dat0_in,
    output logic         busy,
    output logic         done,
    output logic         timeout_err,
    output logic         crc_err,
    output logic         index_err,
    output logic         end_err,
    output logic [127:0] resp_data,
    output logic [63:0]  stat_data,
    output logic         cid_en,
    output logic         csd_en,
    output logic         ocr_en,
    output logic         rca_en,
    output logic         stat_en
);

    typedef enum logic [2:0] {StIdle, StWaitStart, StRecv, StBusy, StFinish} state_e;

    localparam logic [2:0] TypeR1  = 3'd1;
    localparam logic [2:0] TypeR1b = 3'd2;
    localparam logic [2:0] TypeR2  = 3'd3;
    localparam logic [2:0] TypeR3  = 3'd4;
    localparam logic [2:0] TypeR6  = 3'd6;
    localparam logic [7:0] NcrLast = 8'(NCR_MAX - 1);

    state_e         state_q, state_d;
    logic [2:0]     type_q, type_d;
    logic [5:0]     idx_q, idx_d;
    logic           csd_q, csd_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [127:0]   sr_q, sr_d;
    logic [6:0]     crc_q, crc_d;
    logic           frame_bad_q, frame_bad_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           tout_q, tout_d;
    logic           crc_err_q, crc_err_d;
    logic           idx_err_q, idx_err_d;
    logic           end_err_q, end_err_d;
    logic [127:0]   resp_q, resp_d;
    logic [63:0]    stat_q, stat_d;
    logic           cid_en_q, cid_en_d;
    logic           csd_en_q, csd_en_d;
    logic           ocr_en_q, ocr_en_d;
    logic           rca_en_q, rca_en_d;
    logic           stat_en_q, stat_en_d;

    logic       type_valid;
    logic       is_r1, is_r1b, is_r2, is_r3, is_r6;
    logic       crc_bad, idx_bad, end_bad, any_bad;
    logic       crc_fb;
    logic [6:0] crc_step;
    logic [7:0] first_cnt;

`ifndef SD_RESP_BUSY_WAIT_EN
    logic unused_dat0;
    assign unused_dat0 = dat0_in;
`endif

    assign type_valid = (resp_type == TypeR1) || (resp_type == TypeR1b) || (resp_type == TypeR2) ||
                        (resp_type == TypeR3) || (resp_type == TypeR6);
    assign is_r1  = (type_q == TypeR1);
    assign is_r1b = (type_q == TypeR1b);
    assign is_r2  = (type_q == TypeR2);
    assign is_r3  = (type_q == TypeR3);
    assign is_r6  = (type_q == TypeR6);

    // After the frame, sr_q holds the last 128 received bits; sr_q[0] is the end bit.
    assign crc_bad = !is_r3 && (crc_q != sr_q[7:1]);
    assign idx_bad = (is_r1 || is_r1b || is_r6) && (sr_q[45:40] != idx_q);
    assign end_bad = frame_bad_q || !sr_q[0];
    assign any_bad = crc_bad || idx_bad || end_bad;

    assign crc_fb    = cmd_in ^ crc_q[6];
    assign crc_step  = {crc_q[5:3], crc_q[2] ^ crc_fb, crc_q[1:0], crc_fb};
    assign first_cnt = is_r2 ? 8'd135 : 8'd47;

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        idx_d       = idx_q;
        csd_d       = csd_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        crc_d       = crc_q;
        frame_bad_d = frame_bad_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tout_d      = tout_q;
        crc_err_d   = crc_err_q;
        idx_err_d   = idx_err_q;
        end_err_d   = end_err_q;
        resp_d      = resp_q;
        stat_d      = stat_q;
        cid_en_d    = 1'b0;
        csd_en_d    = 1'b0;
        ocr_en_d    = 1'b0;
        rca_en_d    = 1'b0;
        stat_en_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (type_valid) begin
                        type_d      = resp_type;
                        idx_d       = exp_index;
                        csd_d       = r2_is_csd;
                        tout_d      = 1'b0;
                        crc_err_d   = 1'b0;
                        idx_err_d   = 1'b0;
                        end_err_d   = 1'b0;
                        frame_bad_d = 1'b0;
                        crc_d       = 7'd0;
                        cnt_d       = 8'd1;
                        busy_d      = 1'b1;
                        state_d     = StWaitStart;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StWaitStart: begin
                // The arm clock counts as the first Ncr clock.
                if (!cmd_in) begin
                    cnt_d   = first_cnt;
                    state_d = StRecv;
                end else if (cnt_q == NcrLast) begin
                    tout_d  = 1'b1;
                    state_d = StFinish;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StRecv: begin
                // cnt_q - 1 is the frame position of the bit being sampled.
                cnt_d = cnt_q - 8'd1;
                sr_d  = {sr_q[126:0], cmd_in};
                if ((cnt_q == first_cnt) && cmd_in) begin
                    frame_bad_d = 1'b1;
                end
                if ((cnt_q >= 8'd9) && (!is_r2 || (cnt_q <= 8'd128))) begin
                    crc_d = crc_step;
                end
                if (cnt_q == 8'd1) begin
`ifdef SD_RESP_BUSY_WAIT_EN
                    state_d = is_r1b ? StBusy : StFinish;
`else
                    state_d = StFinish;
`endif
                end
            end
            StBusy: begin
`ifdef SD_RESP_BUSY_WAIT_EN
                if (dat0_in) begin
                    state_d = StFinish;
                end
`else
                state_d = StFinish;
`endif
            end
            StFinish: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!tout_q) begin
                    crc_err_d = crc_bad;
                    idx_err_d = idx_bad;
                    end_err_d = end_bad;
                    resp_d    = is_r2 ? {sr_q[127:1], 1'b0} : {96'd0, sr_q[39:8]};
                    if (is_r1 || is_r1b) begin
                        stat_d = {26'd0, sr_q[45:40], sr_q[39:8]};
                    end else if (is_r6) begin
                        stat_d = {26'd0, sr_q[45:40], 16'd0, sr_q[23:8]};
                    end
                    if (!any_bad) begin
                        stat_en_d = is_r1 || is_r1b || is_r6;
                        rca_en_d  = is_r6;
                        ocr_en_d  = is_r3;
                        csd_en_d  = is_r2 && csd_q;
                        cid_en_d  = is_r2 && !csd_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            type_q      <= 3'd0;
            idx_q       <= 6'd0;
            csd_q       <= 1'b0;
            cnt_q       <= 8'd0;
            sr_q        <= 128'd0;
            crc_q       <= 7'd0;
            frame_bad_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tout_q      <= 1'b0;
            crc_err_q   <= 1'b0;
            idx_err_q   <= 1'b0;
            end_err_q   <= 1'b0;
            resp_q      <= 128'd0;
            stat_q      <= 64'd0;
            cid_en_q    <= 1'b0;
            csd_en_q    <= 1'b0;
            ocr_en_q    <= 1'b0;
            rca_en_q    <= 1'b0;
            stat_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            idx_q       <= idx_d;
            csd_q       <= csd_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            crc_q       <= crc_d;
            frame_bad_q <= frame_bad_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tout_q      <= tout_d;
            crc_err_q   <= crc_err_d;
            idx_err_q   <= idx_err_d;
            end_err_q   <= end_err_d;
            resp_q      <= resp_d;
            stat_q      <= stat_d;
            cid_en_q    <= cid_en_d;
            csd_en_q    <= csd_en_d;
            ocr_en_q    <= ocr_en_d;
            rca_en_q    <= rca_en_d;
            stat_en_q   <= stat_en_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = tout_q;
    assign crc_err     = crc_err_q;
    assign index_err   = idx_err_q;
    assign end_err     = end_err_q;
    assign resp_data   = resp_q;
    assign stat_data   = stat_q;
    assign cid_en      = cid_en_q;
    assign csd_en      = csd_en_q;
    assign ocr_en      = ocr_en_q;
    assign rca_en      = rca_en_q;
    assign stat_en     = stat_en_q;

endmodule

// File: tb/tb_sd_cmd_response_rx.sv
// Directed self-checking bench for sd_cmd_response_rx: inputs driven and outputs sampled on negedge.
module tb_sd_cmd_response_rx;

    localparam logic [119:0] R2Body = 120'h400E00325B5900003B377F800A4040;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_in = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   resp_type = 3'd0;
    logic [5:0]   exp_index = 6'd0;
    logic         r2_is_csd = 1'b0;
    logic         dat0_in = 1'b1;
    logic         busy, done, timeout_err, crc_err, index_err, end_err;
    logic [127:0] resp_data;
    logic [63:0]  stat_data;
    logic         cid_en, csd_en, ocr_en, rca_en, stat_en;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [135:0] fr;
    logic [6:0]   c2;

    sd_cmd_response_rx #(.NCR_MAX(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_in      (cmd_in),
        .start       (start),
        .resp_type   (resp_type),
        .exp_index   (exp_index),
        .r2_is_csd   (r2_is_csd),
        .dat0_in     (dat0_in),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .crc_err     (crc_err),
        .index_err   (index_err),
        .end_err     (end_err),
        .resp_data   (resp_data),
        .stat_data   (stat_data),
        .cid_en      (cid_en),
        .csd_en      (csd_en),
        .ocr_en      (ocr_en),
        .rca_en      (rca_en),
        .stat_en     (stat_en)
    );

    always #5 clk = ~clk;

    // {busy, done, timeout, crc, index, end, cid, csd, ocr, rca, stat}
    function automatic logic [10:0] flags();
        return {busy, done, timeout_err, crc_err, index_err, end_err,
                cid_en, csd_en, ocr_en, rca_en, stat_en};
    endfunction

    function automatic logic [6:0] crc7(input logic [127:0] bits, input int n);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = bits[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [135:0] mk48(input logic [5:0] idx, input logic [31:0] content,
                                          input logic [6:0] crc_flip, input logic endb);
        logic [39:0] hdr;
        hdr = {2'b00, idx, content};
        return {88'd0, hdr, crc7({88'd0, hdr}, 40) ^ crc_flip, endb};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        cmd_in = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send(input logic [135:0] f, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cmd_in = f[i];
            tick();
        end
        cmd_in = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    // Inputs other than start are scrambled afterwards so the DUT must have latched them.
    task automatic arm(input logic [2:0] t, input logic [5:0] idx, input logic csd);
        start     = 1'b1;
        resp_type = t;
        exp_index = idx;
        r2_is_csd = csd;
        tick();
        start     = 1'b0;
        resp_type = 3'd0;
        exp_index = 6'h2A;
        r2_is_csd = ~csd;
        cyc       = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("reset_flags", flags(), 11'b0);
        chk("reset_resp", resp_data, 128'd0);
        chk("reset_stat", stat_data, 64'd0);
        reset = 1'b1;
        tick();

        chk("crc_model_cmd0", crc7({88'd0, 40'h4000000000}, 40), 7'h4A);

        // No-response types: done the cycle after start, never busy.
        arm(3'd0, 6'd0, 1'b0);
        chk("none_done", flags(), 11'b01000000000);
        tick();
        chk("none_clear", flags(), 11'b0);
        arm(3'd5, 6'd0, 1'b0);
        chk("type5_done", flags(), 11'b01000000000);
        tick();

        // R1 index 17, status 0x900, 5 idle clocks.
        arm(3'd1, 6'd17, 1'b0);
        chk("r1_busy", flags(), 11'b10000000000);
        idle(5);
        send(mk48(6'd17, 32'h0000_0900, 7'd0, 1'b1), 48);
        chk("r1_pre_done", flags(), 11'b10000000000);
        wait_done(10);
        chk("r1_latency", cyc, 54);
        chk("r1_flags", flags(), 11'b01000000001);
        chk("r1_stat", stat_data, 64'h0000_0011_0000_0900);
        chk("r1_resp", resp_data, 128'h900);
        tick();
        chk("r1_pulse", flags(), 11'b0);

        // R2 CSD with 3 idle clocks; a start during busy must be ignored.
        c2 = crc7({8'd0, R2Body}, 120);
        fr = {2'b00, 6'h3F, R2Body, c2, 1'b1};
        arm(3'd3, 6'd0, 1'b1);
        idle(1);
        start = 1'b1;
        resp_type = 3'd0;
        tick();
        start = 1'b0;
        chk("busy_start_ignored", flags(), 11'b10000000000);
        idle(1);
        send(fr, 136);
        wait_done(10);
        chk("r2_latency", cyc, 140);
        chk("r2_flags", flags(), 11'b01000001000);
        chk("r2_resp", resp_data, {R2Body, c2, 1'b0});
        tick();

        // R3: all-ones index and CRC fields are not flagged.
        arm(3'd4, 6'd0, 1'b0);
        idle(2);
        send({88'd0, 2'b00, 6'h3F, 32'h80FF8000, 7'h7F, 1'b1}, 48);
        wait_done(10);
        chk("r3_flags", flags(), 11'b01000000100);
        chk("r3_resp", resp_data, 128'h80FF8000);
        tick();

        // R6 with a flipped CRC bit, then a clean R6.
        arm(3'd6, 6'd3, 1'b0);
        send(mk48(6'd3, 32'hAAAA_0500, 7'h01, 1'b1), 48);
        wait_done(10);
        chk("r6_crcbad_flags", flags(), 11'b01010000000);
        tick();
        chk("r6_crc_held", flags(), 11'b00010000000);
        arm(3'd6, 6'd3, 1'b0);
        chk("r6_err_cleared", flags(), 11'b10000000000);
        send(mk48(6'd3, 32'hAAAA_0500, 7'd0, 1'b1), 48);
        wait_done(10);
        chk("r6_flags", flags(), 11'b01000000011);
        chk("r6_stat", stat_data, 64'h0000_0003_0000_0500);
        chk("r6_resp", resp_data, 128'hAAAA0500);
        tick();

        // Wrong index, then zero end bit.
        arm(3'd1, 6'd17, 1'b0);
        send(mk48(6'd16, 32'h0000_0900, 7'd0, 1'b1), 48);
        wait_done(10);
        chk("idx_err_flags", flags(), 11'b01001000000);
        tick();
        arm(3'd1, 6'd17, 1'b0);
        send(mk48(6'd17, 32'h0000_0900, 7'd0, 1'b0), 48);
        wait_done(10);
        chk("end_err_flags", flags(), 11'b01000100000);
        tick();

        // Timeout: CMD held high.
        arm(3'd1, 6'd17, 1'b0);
        wait_done(100);
        chk("timeout_latency", cyc, 64);
        chk("timeout_flags", flags(), 11'b01100000000);
        tick();
        chk("timeout_held", flags(), 11'b00100000000);

        // R1b with DAT0 low after the end bit.
        dat0_in = 1'b0;
        arm(3'd2, 6'd7, 1'b0);
        send(mk48(6'd7, 32'h0000_1234, 7'd0, 1'b1), 48);
`ifdef SD_RESP_BUSY_WAIT_EN
        repeat (10) tick();
        chk("r1b_busy_wait", flags(), 11'b10000000000);
        dat0_in = 1'b1;
        cyc = 0;
        wait_done(10);
        chk("r1b_latency", cyc, 2);
`else
        wait_done(10);
        chk("r1b_latency", cyc, 49);
`endif
        chk("r1b_flags", flags(), 11'b01000000001);
        chk("r1b_stat", stat_data, 64'h0000_0007_0000_1234);
        dat0_in = 1'b1;
        tick();

        // Reset in the middle of a frame, then a clean R1.
        fr = mk48(6'd17, 32'h0000_0900, 7'd0, 1'b1);
        arm(3'd1, 6'd17, 1'b0);
        for (int i = 47; i >= 36; i--) begin
            cmd_in = fr[i];
            tick();
        end
        reset = 1'b0;
        #1;
        chk("midreset_flags", flags(), 11'b0);
        chk("midreset_resp", resp_data, 128'd0);
        chk("midreset_stat", stat_data, 64'd0);
        cmd_in = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        arm(3'd1, 6'd17, 1'b0);
        send(fr, 48);
        wait_done(10);
        chk("post_reset_flags", flags(), 11'b01000000001);
        chk("post_reset_stat", stat_data, 64'h0000_0011_0000_0900);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
